// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, resolves
// EX/MEM and MEM/WB forwarding, and detects load-use hazards.
module id_ex_stage #(
  parameter int          WIDTH  = 32,
  parameter int          REG_AW = 5,
  parameter logic [3:0]  OP_ADD = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  id_pc,
  input  logic [WIDTH-1:0]  id_rs1_data,
  input  logic [WIDTH-1:0]  id_rs2_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [3:0]        id_alu_op,
  input  logic              id_src_a_pc,
  input  logic              id_src_b_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_is_branch,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic [WIDTH-1:0]  ex_a,
  output logic [WIDTH-1:0]  ex_b,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [WIDTH-1:0]  ex_pc,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_is_branch
);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [3:0]        alu_op;
    logic              src_a_pc;
    logic              src_b_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_branch;
  } stage_t;

  stage_t           stage_r;
  stage_t           stage_nxt_s;
  logic             load_use_s;
  logic [WIDTH-1:0] fwd_rs1_s;
  logic [WIDTH-1:0] fwd_rs2_s;

  // A bubble is an all-zero slot that still presents ADD to the ALU.
  function automatic stage_t bubble_f();
    stage_t b;
    b        = '0;
    b.alu_op = OP_ADD;
    return b;
  endfunction

  // EX/MEM beats MEM/WB; x0 never forwards so it always reads the latched zero.
  function automatic logic [WIDTH-1:0] forward_f(input logic [REG_AW-1:0] rs,
                                                 input logic [WIDTH-1:0]  rf_data);
    logic [WIDTH-1:0] r;
    if (exmem_reg_write && (exmem_rd != {REG_AW{1'b0}}) && (exmem_rd == rs)) begin
      r = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == rs)) begin
      r = memwb_result;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  // Load in EX whose destination is read by the instruction waiting in decode.
  always_comb begin
    load_use_s = 1'b0;
    if (rst || flush) begin
      load_use_s = 1'b0;
    end else if (id_valid && stage_r.valid && stage_r.mem_read &&
                 (stage_r.rd_addr != {REG_AW{1'b0}}) &&
                 ((stage_r.rd_addr == id_rs1_addr) || (stage_r.rd_addr == id_rs2_addr))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state selection: flush > stall > load-use bubble > capture.
  always_comb begin
    stage_nxt_s = stage_r;
    if (flush) begin
      stage_nxt_s = bubble_f();
    end else if (stall) begin
      stage_nxt_s = stage_r;
    end else if (load_use_s) begin
      stage_nxt_s = bubble_f();
    end else begin
      stage_nxt_s.valid     = id_valid;
      stage_nxt_s.pc        = id_pc;
      stage_nxt_s.rs1_data  = id_rs1_data;
      stage_nxt_s.rs2_data  = id_rs2_data;
      stage_nxt_s.imm       = id_imm;
      stage_nxt_s.rs1_addr  = id_rs1_addr;
      stage_nxt_s.rs2_addr  = id_rs2_addr;
      stage_nxt_s.rd_addr   = id_rd_addr;
      stage_nxt_s.alu_op    = id_alu_op;
      stage_nxt_s.src_a_pc  = id_src_a_pc;
      stage_nxt_s.src_b_imm = id_src_b_imm;
      if (id_valid) begin
        stage_nxt_s.reg_write = id_reg_write;
        stage_nxt_s.mem_read  = id_mem_read;
        stage_nxt_s.mem_write = id_mem_write;
        stage_nxt_s.is_branch = id_is_branch;
      end else begin
        stage_nxt_s.reg_write = 1'b0;
        stage_nxt_s.mem_read  = 1'b0;
        stage_nxt_s.mem_write = 1'b0;
        stage_nxt_s.is_branch = 1'b0;
      end
    end
  end

  // Stage register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= bubble_f();
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  // Forwarding re-evaluates every cycle, including while the stage is stalled.
  always_comb begin
    fwd_rs1_s = forward_f(stage_r.rs1_addr, stage_r.rs1_data);
    fwd_rs2_s = forward_f(stage_r.rs2_addr, stage_r.rs2_data);
  end

  // Operand muxes into the ALU.
  always_comb begin
    ex_a = fwd_rs1_s;
    ex_b = fwd_rs2_s;
    if (stage_r.src_a_pc) begin
      ex_a = stage_r.pc;
    end else begin
      ex_a = fwd_rs1_s;
    end
    if (stage_r.src_b_imm) begin
      ex_b = stage_r.imm;
    end else begin
      ex_b = fwd_rs2_s;
    end
  end

  assign load_use_stall = load_use_s;
  assign ex_valid       = stage_r.valid;
  assign ex_alu_op      = stage_r.alu_op;
  assign ex_store_data  = fwd_rs2_s;
  assign ex_pc          = stage_r.pc;
  assign ex_rd_addr     = stage_r.rd_addr;
  assign ex_reg_write   = stage_r.reg_write & stage_r.valid;
  assign ex_mem_read    = stage_r.mem_read  & stage_r.valid;
  assign ex_mem_write   = stage_r.mem_write & stage_r.valid;
  assign ex_is_branch   = stage_r.is_branch & stage_r.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use,
// stall/flush and PC/immediate operand paths.
module tb_id_ex_stage;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [WIDTH-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]        id_alu_op;
  logic              id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write, id_is_branch;
  logic              stall, flush;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic              exmem_reg_write, memwb_reg_write;
  logic [WIDTH-1:0]  exmem_result, memwb_result;
  logic              load_use_stall, ex_valid;
  logic [3:0]        ex_alu_op;
  logic [WIDTH-1:0]  ex_a, ex_b, ex_store_data, ex_pc;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;

  int tests_run    = 0;
  int tests_failed = 0;

  id_ex_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .OP_ADD(4'b0010)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_is_branch(id_is_branch), .stall(stall), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_id();
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_alu_op = 4'b0010;
    id_src_a_pc = 1'b0; id_src_b_imm = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_is_branch = 1'b0;
  endtask

  task automatic clr_fwd();
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_id();
    clr_fwd();
    stall = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;

    // Reset with random decode inputs
    id_valid = 1'b1; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_pc = $urandom; id_rs1_addr = 5'd6; id_rs2_addr = 5'd6; id_rd_addr = 5'd9;
    id_alu_op = 4'b1111; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_is_branch = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("rst_alu_op", {60'd0, ex_alu_op}, 64'h2);
    check_eq("rst_a", {32'd0, ex_a}, 64'd0);
    check_eq("rst_b", {32'd0, ex_b}, 64'd0);
    check_eq("rst_ctrl", {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}, 64'd0);
    check_eq("rst_lus", {63'd0, load_use_stall}, 64'd0);
    rst = 1'b0;

    // add x3,x1,x2
    clr_id();
    id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd3;
    id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_alu_op = 4'b0010; id_reg_write = 1'b1;
    id_pc = 32'h40;
    tick();
    check_eq("cap_valid", {63'd0, ex_valid}, 64'd1);
    check_eq("cap_a", {32'd0, ex_a}, 64'd5);
    check_eq("cap_b", {32'd0, ex_b}, 64'd7);
    check_eq("cap_op", {60'd0, ex_alu_op}, 64'h2);
    check_eq("cap_rd", {59'd0, ex_rd_addr}, 64'd3);
    check_eq("cap_rw", {63'd0, ex_reg_write}, 64'd1);
    check_eq("cap_pc", {32'd0, ex_pc}, 64'h40);
    check_eq("cap_store", {32'd0, ex_store_data}, 64'd7);

    // Forward priority on rs1=x4
    clr_id();
    id_valid = 1'b1; id_rs1_addr = 5'd4; id_rs2_addr = 5'd8; id_rd_addr = 5'd10;
    id_rs1_data = 32'h44; id_rs2_data = 32'h88; id_imm = 32'h123; id_src_b_imm = 1'b1;
    id_alu_op = 4'b0110; id_reg_write = 1'b1;
    tick();
    clr_id();
    exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'h11;
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'h22;
    #1;
    check_eq("fwd_exmem_wins", {32'd0, ex_a}, 64'h11);
    exmem_reg_write = 1'b0;
    #1;
    check_eq("fwd_memwb", {32'd0, ex_a}, 64'h22);
    memwb_reg_write = 1'b0;
    #1;
    check_eq("fwd_none", {32'd0, ex_a}, 64'h44);
    check_eq("fwd_op", {60'd0, ex_alu_op}, 64'h6);
    memwb_rd = 5'd8; memwb_reg_write = 1'b1; memwb_result = 32'h5A;
    #1;
    check_eq("fwd_imm_b", {32'd0, ex_b}, 64'h123);
    check_eq("fwd_store_rs2", {32'd0, ex_store_data}, 64'h5A);
    clr_fwd();

    // x0 never forwards
    id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd11; id_reg_write = 1'b1;
    tick();
    clr_id();
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h99;
    memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h77;
    #1;
    check_eq("x0_a", {32'd0, ex_a}, 64'd0);
    check_eq("x0_store", {32'd0, ex_store_data}, 64'd0);
    clr_fwd();

    // lw x6, 8(x1)
    id_valid = 1'b1; id_rs1_addr = 5'd1; id_rd_addr = 5'd6; id_imm = 32'd8;
    id_src_b_imm = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1;
    tick();
    check_eq("lw_mem_read", {63'd0, ex_mem_read}, 64'd1);
    // add x7,x5,x6 waits in decode
    clr_id();
    id_rs1_addr = 5'd5; id_rs2_addr = 5'd6; id_rd_addr = 5'd7;
    id_rs1_data = 32'h50; id_rs2_data = 32'h60; id_reg_write = 1'b1; id_alu_op = 4'b0010;
    id_valid = 1'b0;
    #1;
    check_eq("lus_no_id_valid", {63'd0, load_use_stall}, 64'd0);
    id_valid = 1'b1;
    flush = 1'b1;
    #1;
    check_eq("lus_flush_forced", {63'd0, load_use_stall}, 64'd0);
    flush = 1'b0;
    #1;
    check_eq("lus_asserted", {63'd0, load_use_stall}, 64'd1);
    tick();
    check_eq("lus_bubble_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("lus_bubble_rw", {63'd0, ex_reg_write}, 64'd0);
    check_eq("lus_bubble_op", {60'd0, ex_alu_op}, 64'h2);
    check_eq("lus_dropped", {63'd0, load_use_stall}, 64'd0);
    tick();
    check_eq("dep_valid", {63'd0, ex_valid}, 64'd1);
    check_eq("dep_rd", {59'd0, ex_rd_addr}, 64'd7);
    check_eq("dep_rw", {63'd0, ex_reg_write}, 64'd1);
    check_eq("dep_a", {32'd0, ex_a}, 64'h50);

    // Stall holds for 3 cycles while decode presents something else
    clr_id();
    id_valid = 1'b1; id_rd_addr = 5'd9; id_rs1_data = 32'hDEAD; id_mem_write = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_rd", {59'd0, ex_rd_addr}, 64'd7);
      check_eq("stall_a", {32'd0, ex_a}, 64'h50);
      check_eq("stall_mw", {63'd0, ex_mem_write}, 64'd0);
    end
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'hAB;
    #1;
    check_eq("stall_fwd_live", {32'd0, ex_a}, 64'hAB);
    clr_fwd();
    flush = 1'b1;
    tick();
    check_eq("flush_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("flush_rw", {63'd0, ex_reg_write}, 64'd0);
    check_eq("flush_rd", {59'd0, ex_rd_addr}, 64'd0);
    check_eq("flush_op", {60'd0, ex_alu_op}, 64'h2);
    flush = 1'b0;
    stall = 1'b0;

    // Invalid decode slot: data captured, controls cleared
    clr_id();
    id_valid = 1'b0; id_rd_addr = 5'd12; id_pc = 32'h200; id_reg_write = 1'b1;
    id_mem_write = 1'b1; id_is_branch = 1'b1;
    tick();
    check_eq("inv_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("inv_ctrl", {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}, 64'd0);
    check_eq("inv_rd", {59'd0, ex_rd_addr}, 64'd12);

    // Conditional branch
    clr_id();
    id_valid = 1'b1; id_is_branch = 1'b1; id_alu_op = 4'b0110;
    tick();
    check_eq("br_is_branch", {63'd0, ex_is_branch}, 64'd1);

    // auipc: PC and immediate operands
    clr_id();
    id_valid = 1'b1; id_pc = 32'h100; id_imm = 32'h2000; id_src_a_pc = 1'b1; id_src_b_imm = 1'b1;
    id_rs1_data = 32'h3333; id_rs2_data = 32'h4444; id_rd_addr = 5'd13; id_reg_write = 1'b1;
    tick();
    check_eq("auipc_a", {32'd0, ex_a}, 64'h100);
    check_eq("auipc_b", {32'd0, ex_b}, 64'h2000);
    check_eq("auipc_pc", {32'd0, ex_pc}, 64'h100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
